// File: rtl/fir_tap_buffer_pkg.sv
// Shared definitions for the FIR tap buffer: FSM state codes and a width helper.
package fir_pkg;

  localparam logic [1:0] ST_CLEAR  = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  // Bits needed to index 'value' entries, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/fir_tap_buffer_if.sv
// Sample-in / tap-stream-out bundle of the FIR tap buffer.
interface fir_tap_buffer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TAP_W      = 4,
  parameter int CHAN_W     = 1
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [CHAN_W-1:0]     in_chan;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [TAP_W-1:0]      out_tap;
  logic [CHAN_W-1:0]     out_chan;
  logic                  out_last;
  logic                  err_chan;

  modport master (
    output in_valid, in_chan, in_data,
    input  in_ready, out_valid, out_data, out_tap, out_chan, out_last, err_chan
  );

  modport slave (
    input  in_valid, in_chan, in_data,
    output in_ready, out_valid, out_data, out_tap, out_chan, out_last, err_chan
  );

endinterface

// File: rtl/fir_tap_buffer_ram.sv
// Single-clock simple dual-port RAM with a registered, enabled read port.
module fir_tap_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_r;

  // Storage array; contents are established by the owner's clear sweep.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value whenever no read is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r <= '0;
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/fir_tap_buffer.sv
// Multi-channel circular delay line: stores each accepted sample in its channel ring,
// then streams that channel's last TAPS samples newest first.
module fir_tap_buffer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int TAPS       = 16,
  parameter int CHANNELS   = 2
) (
  input  logic             clk,
  input  logic             aclear,
  input  logic             flush,
  fir_tap_buffer_if.slave  bus
);

  localparam int TAP_W     = clog2_min1(TAPS);
  localparam int CHAN_W    = clog2_min1(CHANNELS);
  localparam int MEM_DEPTH = CHANNELS * TAPS;
  localparam int ADDR_W    = clog2_min1(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] TAPS_A    = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [TAP_W-1:0]  LAST_TAP  = TAP_W'(TAPS - 1);
  localparam logic [CHAN_W:0]   CHANS_X   = (CHAN_W + 1)'(CHANNELS);

  logic [1:0]            state_r, state_nx_s;
  logic [ADDR_W-1:0]     clr_cnt_r;
  logic [TAP_W-1:0]      head_r [CHANNELS];
  logic [TAP_W-1:0]      head_sel_s, base_r, tap_cnt_r, tap_off_s, out_tap_r;
  logic [CHAN_W-1:0]     chan_r, out_chan_r;
  logic                  in_ready_r, out_valid_r, out_last_r, err_chan_r;
  logic                  hs_s, bad_chan_s, accept_s, rd_en_s, wr_en_s;
  logic [ADDR_W-1:0]     rd_addr_s, wr_addr_s;
  logic [DATA_WIDTH-1:0] wr_data_s, ram_data_s;

  // Handshake qualification and write-pointer selection for the offered channel.
  always_comb begin
    hs_s       = bus.in_valid && in_ready_r;
    bad_chan_s = ({1'b0, bus.in_chan} >= CHANS_X);
    accept_s   = hs_s && !bad_chan_s && !flush;
    head_sel_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      head_sel_s = (bus.in_chan == CHAN_W'(c)) ? head_r[c] : head_sel_s;
    end
  end

  // Tap k reads slot (base - k) mod TAPS of the latched channel.
  always_comb begin
    if (tap_cnt_r > base_r) begin
      tap_off_s = TAP_W'({1'b0, base_r} + (TAP_W + 1)'(TAPS) - {1'b0, tap_cnt_r});
    end else begin
      tap_off_s = base_r - tap_cnt_r;
    end
    rd_addr_s = ADDR_W'(chan_r) * TAPS_A + ADDR_W'(tap_off_s);
    rd_en_s   = (state_r == ST_STREAM) && !flush;
  end

  // Write port: zero sweep while clearing, otherwise the accepted sample.
  always_comb begin
    if (state_r == ST_CLEAR) begin
      wr_en_s   = 1'b1;
      wr_addr_s = clr_cnt_r;
      wr_data_s = '0;
    end else begin
      wr_en_s   = accept_s;
      wr_addr_s = ADDR_W'(bus.in_chan) * TAPS_A + ADDR_W'(head_sel_s);
      wr_data_s = bus.in_data;
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    if (flush) begin
      state_nx_s = ST_CLEAR;
    end else begin
      case (state_r)
        ST_CLEAR:  state_nx_s = (clr_cnt_r == LAST_ADDR) ? ST_IDLE : ST_CLEAR;
        ST_IDLE:   state_nx_s = accept_s ? ST_STREAM : ST_IDLE;
        ST_STREAM: state_nx_s = (tap_cnt_r == LAST_TAP) ? ST_IDLE : ST_STREAM;
        default:   state_nx_s = ST_CLEAR;
      endcase
    end
  end

  // FSM state, sweep counter and per-stream context.
  always_ff @(posedge clk or negedge aclear) begin
    if (!aclear) begin
      state_r    <= ST_CLEAR;
      in_ready_r <= 1'b0;
      clr_cnt_r  <= '0;
      chan_r     <= '0;
      base_r     <= '0;
      tap_cnt_r  <= '0;
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s == ST_IDLE);
      if (flush || (state_r != ST_CLEAR)) begin
        clr_cnt_r <= '0;
      end else begin
        clr_cnt_r <= clr_cnt_r + ADDR_W'(1);
      end
      if (accept_s) begin
        chan_r    <= bus.in_chan;
        base_r    <= head_sel_s;
        tap_cnt_r <= '0;
      end else if (state_r == ST_STREAM) begin
        tap_cnt_r <= tap_cnt_r + TAP_W'(1);
      end
    end
  end

  // Per-channel write pointers, wrapping at TAPS.
  always_ff @(posedge clk or negedge aclear) begin
    if (!aclear) begin
      for (int c = 0; c < CHANNELS; c++) head_r[c] <= '0;
    end else if (flush) begin
      for (int c = 0; c < CHANNELS; c++) head_r[c] <= '0;
    end else if (accept_s) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (bus.in_chan == CHAN_W'(c)) begin
          head_r[c] <= (head_sel_s == LAST_TAP) ? '0 : head_sel_s + TAP_W'(1);
        end
      end
    end
  end

  // Beat tags line up with the one-cycle RAM read latency.
  always_ff @(posedge clk or negedge aclear) begin
    if (!aclear) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_tap_r   <= '0;
      out_chan_r  <= '0;
    end else if (flush || (state_r != ST_STREAM)) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end else begin
      out_valid_r <= 1'b1;
      out_last_r  <= (tap_cnt_r == LAST_TAP);
      out_tap_r   <= tap_cnt_r;
      out_chan_r  <= chan_r;
    end
  end

  // Sticky out-of-range channel flag.
  always_ff @(posedge clk or negedge aclear) begin
    if (!aclear) begin
      err_chan_r <= 1'b0;
    end else if (flush) begin
      err_chan_r <= 1'b0;
    end else if (hs_s && bad_chan_s) begin
      err_chan_r <= 1'b1;
    end
  end

  fir_tap_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (aclear),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (ram_data_s)
  );

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = ram_data_s;
  assign bus.out_tap   = out_tap_r;
  assign bus.out_chan  = out_chan_r;
  assign bus.out_last  = out_last_r;
  assign bus.err_chan  = err_chan_r;

endmodule

// File: tb/tb_fir_tap_buffer.sv
// Self-checking bench for fir_tap_buffer (TAPS=4, CHANNELS=3) against a history-array model.
module tb_fir_tap_buffer;

  localparam int DW    = 16;
  localparam int TAPS  = 4;
  localparam int CHANS = 3;
  localparam int SWEEP = CHANS * TAPS;

  logic clk, aclear, flush;
  int   n_checks, n_fail;

  // Model: per-channel history, newest sample at index 0.
  logic [DW-1:0] hist [CHANS][TAPS];
  bit            err_m;
  logic [DW-1:0] held_data;
  int            held_tap, held_chan;

  fir_tap_buffer_if #(.DATA_WIDTH(DW), .TAP_W(2), .CHAN_W(2)) bif ();

  fir_tap_buffer #(.DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(CHANS)) dut (
    .clk    (clk),
    .aclear (aclear),
    .flush  (flush),
    .bus    (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CHANS; c++)
      for (int t = 0; t < TAPS; t++) hist[c][t] = '0;
    err_m = 1'b0;
  endtask

  // Current cycle is the first of the clear sweep.
  task automatic sweep_check();
    for (int i = 0; i < SWEEP; i++) begin
      chk("sweep_ready", bif.in_ready, 0);
      chk("sweep_valid", bif.out_valid, 0);
      chk("sweep_err", bif.err_chan, err_m);
      step();
    end
    chk("sweep_done_ready", bif.in_ready, 1);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    model_clear();
    sweep_check();
  endtask

  // Offer one sample; check its stream. flush_at >= 0 flushes while that tap is on output.
  task automatic push(input int ch, input logic [DW-1:0] d, input int flush_at);
    int n;
    logic [DW-1:0] exp_v [TAPS];
    n = 0;
    while (bif.in_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("ready_wait", bif.in_ready, 1);
    bif.in_valid = 1'b1;
    bif.in_chan  = ch[1:0];
    bif.in_data  = d;
    step();
    bif.in_valid = 1'b0;
    chk("gap_valid", bif.out_valid, 0);
    chk("hold_data", bif.out_data, held_data);
    chk("hold_tap", bif.out_tap, held_tap);
    chk("hold_chan", bif.out_chan, held_chan);
    if (ch >= CHANS) begin
      err_m = 1'b1;
      for (int i = 0; i < TAPS + 1; i++) begin
        chk("bad_ready", bif.in_ready, 1);
        chk("bad_valid", bif.out_valid, 0);
        chk("bad_err", bif.err_chan, 1);
        step();
      end
      return;
    end
    chk("busy_ready", bif.in_ready, 0);
    for (int t = TAPS - 1; t > 0; t--) hist[ch][t] = hist[ch][t-1];
    hist[ch][0] = d;
    for (int t = 0; t < TAPS; t++) exp_v[t] = hist[ch][t];
    for (int k = 0; k < TAPS; k++) begin
      step();
      chk("beat_valid", bif.out_valid, 1);
      chk("beat_data", bif.out_data, exp_v[k]);
      chk("beat_tap", bif.out_tap, k);
      chk("beat_chan", bif.out_chan, ch);
      chk("beat_last", bif.out_last, (k == TAPS - 1) ? 1 : 0);
      chk("beat_ready", bif.in_ready, (k == TAPS - 1) ? 1 : 0);
      chk("beat_err", bif.err_chan, err_m);
      held_data = exp_v[k];
      held_tap  = k;
      held_chan = ch;
      if (k == flush_at) begin
        do_flush();
        return;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    aclear = 1'b0;
    flush = 1'b0;
    bif.in_valid = 1'b0;
    bif.in_chan = '0;
    bif.in_data = '0;
    model_clear();
    held_data = '0;
    held_tap = 0;
    held_chan = 0;

    // Reset values, then the initial clear sweep.
    repeat (3) step();
    chk("rst_ready", bif.in_ready, 0);
    chk("rst_valid", bif.out_valid, 0);
    chk("rst_data", bif.out_data, 0);
    chk("rst_tap", bif.out_tap, 0);
    chk("rst_chan", bif.out_chan, 0);
    chk("rst_last", bif.out_last, 0);
    chk("rst_err", bif.err_chan, 0);
    aclear = 1'b1;
    sweep_check();

    // Ring wrap on channel 0.
    for (int i = 1; i <= 5; i++) push(0, 16'(i), -1);

    // Fresh channel after clear reads zeros for unwritten taps.
    do_flush();
    push(1, 16'd7, -1);

    // Back-to-back pushes across channels.
    push(0, 16'd10, -1);
    push(2, 16'd20, -1);
    push(0, 16'd11, -1);

    // Flush mid-stream, then a clean restart.
    push(0, 16'd33, 1);
    push(0, 16'd9, -1);

    // Out-of-range channel: sticky error, history intact, flush clears it.
    push(3, 16'hBEEF, -1);
    push(0, 16'd44, -1);
    chk("err_sticky", bif.err_chan, 1);
    do_flush();
    chk("err_cleared", bif.err_chan, 0);

    // Randomized traffic with occasional mid-stream flushes and idle gaps.
    for (int i = 0; i < 40; i++) begin
      int ch, fa;
      ch = int'($urandom_range(0, 3));
      fa = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TAPS - 1)) : -1;
      push(ch, 16'($urandom), fa);
      repeat ($urandom_range(0, 2)) step();
    end

    // Asynchronous reset in the middle of a stream.
    bif.in_valid = 1'b1;
    bif.in_chan = 2'd1;
    bif.in_data = 16'h1234;
    step();
    bif.in_valid = 1'b0;
    step();
    aclear = 1'b0;
    #1;
    chk("arst_valid", bif.out_valid, 0);
    chk("arst_data", bif.out_data, 0);
    chk("arst_ready", bif.in_ready, 0);
    chk("arst_err", bif.err_chan, 0);
    #1;
    aclear = 1'b1;
    model_clear();
    held_data = '0;
    held_tap = 0;
    held_chan = 0;
    sweep_check();
    push(1, 16'h5555, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
